// File: rtl/fp16_align_pkg.sv
// Types and the sticky right-shift helper for the binary16 alignment stage.
package fp16_align_pkg;
  `include "fp16_defs.vh"

  typedef enum logic [1:0] {
    SPEC_NORMAL = SPC_NORMAL,
    SPEC_INF    = SPC_INF,
    SPEC_NAN    = SPC_NAN,
    SPEC_ZERO   = SPC_ZERO
  } special_e;

  typedef struct packed {
    logic              signL;
    logic              sub;
    logic [EXP_W-1:0]  expL;
    logic [MANT_W-1:0] mantL;
    logic [MANT_W-1:0] mantRawS;
    logic [EXP_W-1:0]  shamt;
    special_e          special;
    logic [15:0]       specVal;
  } stage1_t;

  typedef struct packed {
    logic              signL;
    logic              sub;
    logic [EXP_W-1:0]  expL;
    logic [MANT_W-1:0] mantL;
    logic [ALN_W-1:0]  mantS;
    special_e          special;
    logic [15:0]       specVal;
  } stage2_t;

  // Bits that fall off the right are folded into bit 0; huge shifts leave only sticky.
  function automatic logic [ALN_W-1:0] alignShift(input logic [MANT_W-1:0] mant,
                                                  input logic [EXP_W-1:0]  shamt);
    logic [2*ALN_W-1:0] wide;
    logic [ALN_W-1:0]   res;
    wide = '0;
    if (shamt >= EXP_W'(ALN_W)) begin
      res = {{(ALN_W-1){1'b0}}, |mant};
    end else begin
      wide = {mant, {(ALN_W-MANT_W){1'b0}}, {ALN_W{1'b0}}} >> shamt;
      res  = wide[2*ALN_W-1:ALN_W] | {{(ALN_W-1){1'b0}}, |wide[ALN_W-1:0]};
    end
    return res;
  endfunction
endpackage

// File: rtl/fp16_align_if.sv
// Operand-pair input handshake and aligned-result output handshake of fp16_align.
interface fp16_align_if;
  import fp16_align_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [15:0]       a;
  logic [15:0]       b;
  logic              out_valid;
  logic              out_ready;
  logic              sign_l;
  logic              sub;
  logic [EXP_W-1:0]  exp_l;
  logic [MANT_W-1:0] mant_l;
  logic [ALN_W-1:0]  mant_s;
  logic [1:0]        special;
  logic [15:0]       spec_val;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sign_l, sub, exp_l, mant_l, mant_s, special, spec_val
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sign_l, sub, exp_l, mant_l, mant_s, special, spec_val
  );
endinterface

// File: rtl/fp16_align_unpack.sv
// Combinational binary16 field decoder: subnormals get exponent 1 and hidden bit 0.
module fp16_unpack
  import fp16_align_pkg::*;
(
  input  logic [15:0]       op_i,
  output logic              sign_o,
  output logic [EXP_W-1:0]  exp_o,
  output logic [MANT_W-1:0] mant_o,
  output logic              isZero_o,
  output logic              isInf_o,
  output logic              isNan_o
);
  logic [EXP_W-1:0]  rawExp;
  logic [FRAC_W-1:0] frac;
  logic              expZero;
  logic              expMax;

  assign rawExp  = op_i[FRAC_W +: EXP_W];
  assign frac    = op_i[FRAC_W-1:0];
  assign expZero = (rawExp == '0);
  assign expMax  = &rawExp;

  assign sign_o   = op_i[15];
  assign exp_o    = expZero ? EXP_W'(1) : rawExp;
  assign mant_o   = {!expZero, frac};
  assign isZero_o = expZero && (frac == '0);
  assign isInf_o  = expMax && (frac == '0);
  assign isNan_o  = expMax && (frac != '0);
endmodule

// File: rtl/fp16_defs.vh
// Shared binary16 widths, special-result codes and canonical NaN.
// Textually included into a package scope so fpadd can reuse the same values.
localparam int EXP_W  = 5;
localparam int FRAC_W = 10;
localparam int MANT_W = 11;
localparam int ALN_W  = 14;

localparam logic [1:0] SPC_NORMAL = 2'b00;
localparam logic [1:0] SPC_INF    = 2'b01;
localparam logic [1:0] SPC_NAN    = 2'b10;
localparam logic [1:0] SPC_ZERO   = 2'b11;

localparam logic [15:0] CANON_NAN = 16'h7E00;

// File: rtl/fp16_align.sv
// Two-stage binary16 pre-adder: stage 1 unpacks, compares and swaps, stage 2 aligns
// the smaller significand with guard/round/sticky bits.
module fp16_align
  import fp16_align_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  fp16_align_if.slave  alignBus_io
);
  logic              signA, signB, zeroA, zeroB, infA, infB, nanA, nanB;
  logic [EXP_W-1:0]  expA, expB;
  logic [MANT_W-1:0] mantA, mantB;

  fp16_unpack uUnpackA (
    .op_i(alignBus_io.a), .sign_o(signA), .exp_o(expA), .mant_o(mantA),
    .isZero_o(zeroA), .isInf_o(infA), .isNan_o(nanA)
  );

  fp16_unpack uUnpackB (
    .op_i(alignBus_io.b), .sign_o(signB), .exp_o(expB), .mant_o(mantB),
    .isZero_o(zeroB), .isInf_o(infB), .isNan_o(nanB)
  );

  stage1_t s1_q, s1_d, s1New;
  stage2_t out_q, out_d;
  logic    s1Valid_q, s1Valid_d;
  logic    outValid_q, outValid_d;
  logic    s2Free, s1Adv, inReady, accept, aLarger;

  // out_ready -> in_ready is the only combinational path through the stage.
  assign s2Free  = !outValid_q || alignBus_io.out_ready;
  assign s1Adv   = s1Valid_q && s2Free;
  assign inReady = !rst && (!s1Valid_q || s2Free);
  assign accept  = alignBus_io.in_valid && inReady;

  // Magnitude compare on raw {exp, frac}; ties go to a.
  always_comb begin
    s1New   = '0;
    aLarger = (alignBus_io.a[14:0] >= alignBus_io.b[14:0]);
    s1New.sub = signA ^ signB;
    if (aLarger) begin
      s1New.signL    = signA;
      s1New.expL     = expA;
      s1New.mantL    = mantA;
      s1New.mantRawS = mantB;
      s1New.shamt    = expA - expB;
    end else begin
      s1New.signL    = signB;
      s1New.expL     = expB;
      s1New.mantL    = mantB;
      s1New.mantRawS = mantA;
      s1New.shamt    = expB - expA;
    end
    if (nanA || nanB || (infA && infB && (signA != signB))) begin
      s1New.special = SPEC_NAN;
      s1New.specVal = CANON_NAN;
    end else if (infA) begin
      s1New.special = SPEC_INF;
      s1New.specVal = alignBus_io.a;
    end else if (infB) begin
      s1New.special = SPEC_INF;
      s1New.specVal = alignBus_io.b;
    end else if (zeroA && zeroB) begin
      s1New.special = SPEC_ZERO;
      s1New.specVal = {signA && signB, 15'h0000};
    end
  end

  always_comb begin
    s1Valid_d  = s1Valid_q;
    s1_d       = s1_q;
    outValid_d = outValid_q;
    out_d      = out_q;
    if (s1Adv) begin
      s1Valid_d = 1'b0;
    end
    if (accept) begin
      s1Valid_d = 1'b1;
      s1_d      = s1New;
    end
    if (s2Free) begin
      outValid_d = s1Valid_q;
    end
    if (s1Adv) begin
      out_d.signL   = s1_q.signL;
      out_d.sub     = s1_q.sub;
      out_d.expL    = s1_q.expL;
      out_d.mantL   = s1_q.mantL;
      out_d.mantS   = alignShift(s1_q.mantRawS, s1_q.shamt);
      out_d.special = s1_q.special;
      out_d.specVal = s1_q.specVal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q  <= 1'b0;
      s1_q       <= '0;
      outValid_q <= 1'b0;
      out_q      <= '0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1_q       <= s1_d;
      outValid_q <= outValid_d;
      out_q      <= out_d;
    end
  end

  assign alignBus_io.in_ready  = inReady;
  assign alignBus_io.out_valid = outValid_q;
  assign alignBus_io.sign_l    = out_q.signL;
  assign alignBus_io.sub       = out_q.sub;
  assign alignBus_io.exp_l     = out_q.expL;
  assign alignBus_io.mant_l    = out_q.mantL;
  assign alignBus_io.mant_s    = out_q.mantS;
  assign alignBus_io.special   = out_q.special;
  assign alignBus_io.spec_val  = out_q.specVal;
endmodule

// File: tb/tb_fp16_align.sv
// Bench for fp16_align: directed vector table, stall/reset sequences and a
// randomized scoreboard checked against an arithmetic reference model.
module tb_fp16_align;
  typedef struct packed {
    logic        signL;
    logic        sub;
    logic [4:0]  expL;
    logic [10:0] mantL;
    logic [13:0] mantS;
    logic [1:0]  special;
    logic [15:0] specVal;
  } res_t;

  typedef struct packed {
    res_t r;
    logic cmpData;
  } expect_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    res_t        r;
    bit          cmpData;
  } vec_t;

  localparam int NUM_VEC = 18;
  localparam int NUM_RAND = 400;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp16_align_if alignBus();

  fp16_align dut (
    .clk(clk),
    .rst(rst),
    .alignBus_io(alignBus)
  );

  int      checks = 0;
  int      errors = 0;
  int      acceptCnt = 0;
  int      consumeCnt = 0;
  bit      lastAccept = 1'b0;
  bit      lastStall = 1'b0;
  res_t    lastOut;
  res_t    monCur;
  expect_t monExp;
  expect_t expQ[$];
  vec_t    vecs[NUM_VEC];

  function automatic int effExp(input int e);
    return (e == 0) ? 1 : e;
  endfunction

  function automatic int sigOf(input int e, input int f);
    return ((e == 0) ? 0 : 1024) + f;
  endfunction

  // Reference: decode to integers, pick the larger magnitude, shift with sticky.
  function automatic res_t refModel(input logic [15:0] a, input logic [15:0] b);
    res_t r;
    int   ea, eb, fa, fb, effL, effS, sigL, sigS, d, full, ms;
    bit   aBig, nanA, nanB, infA, infB, zeroA, zeroB;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    fa = int'(a[9:0]);
    fb = int'(b[9:0]);
    aBig = int'(a[14:0]) >= int'(b[14:0]);
    effL = aBig ? effExp(ea) : effExp(eb);
    effS = aBig ? effExp(eb) : effExp(ea);
    sigL = aBig ? sigOf(ea, fa) : sigOf(eb, fb);
    sigS = aBig ? sigOf(eb, fb) : sigOf(ea, fa);
    r = '0;
    r.signL = aBig ? a[15] : b[15];
    r.sub   = a[15] ^ b[15];
    r.expL  = 5'(effL);
    r.mantL = 11'(sigL);
    d = effL - effS;
    full = sigS * 8;
    if (d >= 14) ms = (sigS != 0) ? 1 : 0;
    else ms = (full >> d) | (((full % (1 << d)) != 0) ? 1 : 0);
    r.mantS = 14'(ms);
    nanA = (ea == 31) && (fa != 0);
    nanB = (eb == 31) && (fb != 0);
    infA = (ea == 31) && (fa == 0);
    infB = (eb == 31) && (fb == 0);
    zeroA = (ea == 0) && (fa == 0);
    zeroB = (eb == 0) && (fb == 0);
    if (nanA || nanB || (infA && infB && (a[15] != b[15]))) begin
      r.special = 2'b10;
      r.specVal = 16'h7E00;
    end else if (infA || infB) begin
      r.special = 2'b01;
      r.specVal = infA ? a : b;
    end else if (zeroA && zeroB) begin
      r.special = 2'b11;
      r.specVal = (a[15] && b[15]) ? 16'h8000 : 16'h0000;
    end
    return r;
  endfunction

  function automatic bit isDataCmp(input logic [15:0] a, input logic [15:0] b);
    return (a[14:10] != 5'h1F) && (b[14:10] != 5'h1F);
  endfunction

  function automatic res_t mkRes(input logic sl, input logic sb, input logic [4:0] el,
                                 input logic [10:0] ml, input logic [13:0] ms,
                                 input logic [1:0] sp, input logic [15:0] sv);
    res_t r;
    r.signL = sl; r.sub = sb; r.expL = el; r.mantL = ml;
    r.mantS = ms; r.special = sp; r.specVal = sv;
    return r;
  endfunction

  function automatic res_t captureOut();
    return mkRes(alignBus.sign_l, alignBus.sub, alignBus.exp_l, alignBus.mant_l,
                 alignBus.mant_s, alignBus.special, alignBus.spec_val);
  endfunction

  function automatic logic [15:0] randOperand();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 9))
      0: v[14:0] = 15'h0000;
      1: v[14:0] = 15'h7C00;
      2: begin
        v[14:10] = 5'h1F;
        if (v[9:0] == 10'h000) v[0] = 1'b1;
      end
      3: v[14:10] = 5'h00;
      4, 5: v[14:10] = 5'(13 + $urandom_range(0, 4));
      default: ;
    endcase
    return v;
  endfunction

  task automatic checkSignal(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic checkOutput(input string name, input res_t act, input res_t expv, input bit cmpData);
    res_t m;
    m = '1;
    if (!cmpData) begin
      m.signL = 1'b0; m.sub = 1'b0; m.expL = '0; m.mantL = '0; m.mantS = '0;
    end
    if (expv.special == 2'b00) m.specVal = '0;
    checks++;
    if ((act & m) !== (expv & m)) begin
      errors++;
      $display("[TB] FAIL %s: got sign=%b sub=%b exp=%h mantL=%h mantS=%h special=%b val=%h, expected sign=%b sub=%b exp=%h mantL=%h mantS=%h special=%b val=%h",
               name, act.signL, act.sub, act.expL, act.mantL, act.mantS, act.special, act.specVal,
               expv.signL, expv.sub, expv.expL, expv.mantL, expv.mantS, expv.special, expv.specVal);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
    alignBus.in_valid = 1'b1;
    alignBus.a = a;
    alignBus.b = b;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((expQ.size() != 0 || alignBus.out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkSignal(name, 64'(expQ.size() != 0 || alignBus.out_valid), 64'd0);
  endtask

  // Scoreboard monitor sampling on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      lastStall = 1'b0;
      lastAccept = 1'b0;
    end else begin
      monCur = captureOut();
      if (lastStall) begin
        checkSignal("holdValid", 64'(alignBus.out_valid), 64'd1);
        checkOutput("holdData", monCur, lastOut, 1'b1);
      end
      if (alignBus.out_valid && alignBus.out_ready) begin
        consumeCnt++;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected: output with empty scoreboard, got mantS=%h", monCur.mantS);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("scoreboard", monCur, monExp.r, monExp.cmpData);
        end
      end
      lastAccept = alignBus.in_valid && alignBus.in_ready;
      if (lastAccept) begin
        monExp.r = refModel(alignBus.a, alignBus.b);
        monExp.cmpData = isDataCmp(alignBus.a, alignBus.b);
        expQ.push_back(monExp);
        acceptCnt++;
      end
      lastStall = alignBus.out_valid && !alignBus.out_ready;
      lastOut = monCur;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base, baseC, cyc;
    alignBus.in_valid = 1'b0;
    alignBus.out_ready = 1'b1;
    alignBus.a = 16'h0000;
    alignBus.b = 16'h0000;

    vecs[0]  = '{16'h3C00, 16'h3800, mkRes(0, 0, 5'h0F, 11'h400, 14'h1000, 2'b00, 16'h0000), 1};
    vecs[1]  = '{16'h3800, 16'hBC00, mkRes(1, 1, 5'h0F, 11'h400, 14'h1000, 2'b00, 16'h0000), 1};
    vecs[2]  = '{16'h6400, 16'h0001, mkRes(0, 0, 5'h19, 11'h400, 14'h0001, 2'b00, 16'h0000), 1};
    vecs[3]  = '{16'h7C00, 16'hFC00, mkRes(0, 0, 5'h00, 11'h000, 14'h0000, 2'b10, 16'h7E00), 0};
    vecs[4]  = '{16'h8000, 16'h8000, mkRes(1, 0, 5'h01, 11'h000, 14'h0000, 2'b11, 16'h8000), 1};
    vecs[5]  = '{16'h0000, 16'h8000, mkRes(0, 1, 5'h01, 11'h000, 14'h0000, 2'b11, 16'h0000), 1};
    vecs[6]  = '{16'h3C00, 16'h3C00, mkRes(0, 0, 5'h0F, 11'h400, 14'h2000, 2'b00, 16'h0000), 1};
    vecs[7]  = '{16'h3C01, 16'h3400, mkRes(0, 0, 5'h0F, 11'h401, 14'h0800, 2'b00, 16'h0000), 1};
    vecs[8]  = '{16'h4C00, 16'h3C01, mkRes(0, 0, 5'h13, 11'h400, 14'h0201, 2'b00, 16'h0000), 1};
    vecs[9]  = '{16'h3000, 16'h0401, mkRes(0, 0, 5'h0C, 11'h400, 14'h0005, 2'b00, 16'h0000), 1};
    vecs[10] = '{16'h3800, 16'h0400, mkRes(0, 0, 5'h0E, 11'h400, 14'h0001, 2'b00, 16'h0000), 1};
    vecs[11] = '{16'h3C00, 16'h0400, mkRes(0, 0, 5'h0F, 11'h400, 14'h0001, 2'b00, 16'h0000), 1};
    vecs[12] = '{16'h3C00, 16'h0000, mkRes(0, 0, 5'h0F, 11'h400, 14'h0000, 2'b00, 16'h0000), 1};
    vecs[13] = '{16'h7C00, 16'h3C00, mkRes(0, 0, 5'h00, 11'h000, 14'h0000, 2'b01, 16'h7C00), 0};
    vecs[14] = '{16'h3C00, 16'h7E01, mkRes(0, 0, 5'h00, 11'h000, 14'h0000, 2'b10, 16'h7E00), 0};
    vecs[15] = '{16'hFC00, 16'hFC00, mkRes(0, 0, 5'h00, 11'h000, 14'h0000, 2'b01, 16'hFC00), 0};
    vecs[16] = '{16'h0003, 16'h0001, mkRes(0, 0, 5'h01, 11'h003, 14'h0008, 2'b00, 16'h0000), 1};
    vecs[17] = '{16'hBC00, 16'h3C00, mkRes(1, 1, 5'h0F, 11'h400, 14'h2000, 2'b00, 16'h0000), 1};

    // Reset state.
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkSignal("rstOutValid", 64'(alignBus.out_valid), 64'd0);
    checkSignal("rstInReady", 64'(alignBus.in_ready), 64'd0);
    checkSignal("rstData", 64'(captureOut()), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkSignal("postRstInReady", 64'(alignBus.in_ready), 64'd1);

    // Directed table with latency checks.
    for (int i = 0; i < NUM_VEC; i++) begin
      @(posedge clk);
      #1 applyStimulus(vecs[i].a, vecs[i].b);
      @(negedge clk);
      checkSignal("vecInReady", 64'(alignBus.in_ready), 64'd1);
      @(posedge clk);
      #1 alignBus.in_valid = 1'b0;
      @(negedge clk);
      checkSignal("vecLatency1", 64'(alignBus.out_valid), 64'd0);
      @(negedge clk);
      checkSignal("vecLatency2", 64'(alignBus.out_valid), 64'd1);
      checkOutput($sformatf("vec%0d", i), captureOut(), vecs[i].r, vecs[i].cmpData);
    end
    waitDrain("vecDrain");

    // Backpressure: five stalled cycles while three pairs are offered.
    @(posedge clk);
    #1;
    base = acceptCnt;
    baseC = consumeCnt;
    alignBus.out_ready = 1'b0;
    applyStimulus(16'h3C00, 16'h3800);
    @(posedge clk);
    #1 applyStimulus(16'h4C00, 16'h3C01);
    @(posedge clk);
    #1 applyStimulus(16'h5555, 16'h1234);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkSignal("bpInReady", 64'(alignBus.in_ready), 64'd0);
      checkSignal("bpOutValid", 64'(alignBus.out_valid), 64'd1);
      @(posedge clk);
      #1;
    end
    checkSignal("bpAccepted", 64'(acceptCnt - base), 64'd2);
    alignBus.out_ready = 1'b1;
    @(posedge clk);
    #1 alignBus.in_valid = 1'b0;
    waitDrain("bpDrain");
    checkSignal("bpEmitted", 64'(consumeCnt - baseC), 64'd3);
    checkSignal("bpAcceptedAll", 64'(acceptCnt - base), 64'd3);

    // Asynchronous reset while a result is held on the output.
    @(posedge clk);
    #1 alignBus.out_ready = 1'b0;
    applyStimulus(16'h3C00, 16'h3800);
    @(posedge clk);
    #1 alignBus.in_valid = 1'b0;
    @(posedge clk);
    #1 checkSignal("preRstValid", 64'(alignBus.out_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    checkSignal("asyncRstValid", 64'(alignBus.out_valid), 64'd0);
    checkSignal("asyncRstReady", 64'(alignBus.in_ready), 64'd0);
    checkSignal("asyncRstData", 64'(captureOut()), 64'd0);
    expQ.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    alignBus.out_ready = 1'b1;
    #1 checkSignal("relInReady", 64'(alignBus.in_ready), 64'd1);
    applyStimulus(16'h4C00, 16'h3C01);
    @(posedge clk);
    #1 alignBus.in_valid = 1'b0;
    @(negedge clk);
    checkSignal("relLatency1", 64'(alignBus.out_valid), 64'd0);
    @(negedge clk);
    checkSignal("relLatency2", 64'(alignBus.out_valid), 64'd1);
    checkOutput("relFirst", captureOut(), refModel(16'h4C00, 16'h3C01), 1'b1);
    waitDrain("relDrain");

    // Randomized traffic with random backpressure.
    base = acceptCnt;
    cyc = 0;
    while ((acceptCnt - base) < NUM_RAND && cyc < 20000) begin
      @(posedge clk);
      #1;
      if (!alignBus.in_valid || lastAccept) begin
        alignBus.in_valid = ($urandom_range(0, 3) != 0);
        alignBus.a = randOperand();
        alignBus.b = randOperand();
      end
      alignBus.out_ready = ($urandom_range(0, 3) != 0);
      cyc++;
    end
    checkSignal("randBudget", 64'((acceptCnt - base) >= NUM_RAND), 64'd1);
    alignBus.in_valid = 1'b0;
    alignBus.out_ready = 1'b1;
    waitDrain("randDrain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp16_align.md
FP16_ALIGN -- requirements
Module: fp16_align

Interface
REQ-001 Parameters: none; all widths are fixed to IEEE-754 binary16.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  operand pair a/b valid this cycle.
REQ-005 in_ready  output  1  stage accepts pair when in_valid & in_ready.
REQ-006 a, b  input  16 each  binary16 operands.
REQ-007 out_valid  output  1  aligned result valid.
REQ-008 out_ready  input  1  downstream adder core consumes when out_valid & out_ready.
REQ-009 sign_l  output  1  sign of larger-magnitude operand.
REQ-010 sub  output  1  effective subtraction, sign(a) XOR sign(b).
REQ-011 exp_l  output  5  biased exponent of larger operand; 1 for subnormal.
REQ-012 mant_l  output  11  larger significand, hidden bit included.
REQ-013 mant_s  output  14  smaller significand, hidden bit included, shifted right; bits [2:0] are guard, round, sticky.
REQ-014 special  output  2  00 normal, 01 infinity, 10 NaN, 11 both zero.
REQ-015 spec_val  output  16  final result when special != 00.

Function
REQ-016 Latency SHALL be 2 cycles from acceptance to out_valid with no stall. Stage 1 registers unpack, compare and swap; stage 2 registers the shift.
REQ-017 Throughput SHALL be one pair per cycle while out_ready=1.
REQ-018 in_ready SHALL equal NOT stage-1-valid OR stage 1 advancing. Combinational paths SHALL be limited to out_ready -> in_ready.
REQ-019 While out_valid=1 and out_ready=0, all outputs SHALL hold stable.
REQ-020 A pipeline with both stages full SHALL hold exactly 2 pairs without loss or reordering.
REQ-021 Unpack rules:
  - exp=0: hidden bit 0, effective exponent 1.
  - exp 1..30: hidden bit 1.
REQ-022 Larger operand: compared on {exp, frac}. On equality, a SHALL be taken as larger.
REQ-023 Shift amount d = exp_l - exp_s.
  - mant_s = ({mant_s_raw, 3'b000} >> d), with bit 0 ORed with every bit shifted out.
  - For d >= 14: mant_s = 14'h0001 if mant_s_raw != 0, else 0.
REQ-024 NaN handling: either operand NaN, or +inf plus -inf, SHALL give special=10 and spec_val=16'h7E00.
REQ-025 Infinity handling: otherwise, any infinity SHALL give special=01 and spec_val = that infinity. If both operands are infinite with the same sign, spec_val is that infinity.
REQ-026 Both-zero handling: both operands ±0 SHALL give special=11. spec_val = 16'h8000 only if both operands are -0, else 16'h0000.
REQ-027 When special != 00, the datapath outputs SHALL still follow REQ-021..023 (don't-care for downstream).

Reset
REQ-028 RST=1 SHALL immediately clear both stage valid flags; out_valid=0 and in_ready=0 while RST=1.
REQ-029 On RST, all data outputs SHALL reset to 0 and special SHALL reset to 00.
REQ-030 Reset mid-operation SHALL discard in-flight pairs. in_ready=1 on the first edge after RST deasserts.

Structure
REQ-031 Shared include fp16_defs.vh SHALL hold the following, for reuse by fpadd:
  - EXP_W=5, FRAC_W=10, MANT_W=11, ALN_W=14;
  - special codes;
  - canonical NaN 16'h7E00.
REQ-032 One sub-module, fp16_unpack, SHALL be instantiated twice. It is combinational and outputs sign, effective exp, significand, is_zero, is_inf, is_nan.

Verification
REQ-033 a=3C00, b=3800 -> after 2 cycles: sign_l=0, sub=0, exp_l=0F, mant_l=400, mant_s=1000, special=00.
REQ-034 a=3800, b=BC00 -> swap: sign_l=1, sub=1, exp_l=0F, mant_l=400, mant_s=1000.
REQ-035 a=6400, b=0001 (d=24) -> mant_s=0001 (sticky only), exp_l=19.
REQ-036 Special cases:
  - a=7C00, b=FC00 -> special=10, spec_val=7E00.
  - a=8000, b=8000 -> special=11, spec_val=8000.
REQ-037 Backpressure: hold out_ready=0 for 5 cycles while offering 3 pairs -> in_ready falls after 2 accepted. On release, 3 results emerge in order with no duplicates, and outputs are stable during the stall.
REQ-038 Reset mid-operation: assert RST asynchronously with out_valid=1 -> out_valid=0 before the next edge. The first pair after release appears after 2 cycles.
